// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-channel control-bit synchroniser.
// The stage-range check macro is defined here so every user sees the same limits.
package sync_pkg;
  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

`define SYNC_CHECK_STAGES(n) \
  if ((n) < sync_pkg::MIN_SYNC_STAGES || (n) > sync_pkg::MAX_SYNC_STAGES) begin : g_bad_stages \
    $error("NUM_STAGES must lie within MIN_SYNC_STAGES..MAX_SYNC_STAGES"); \
  end

// File: rtl/sync_chan.sv
// One synchronised channel: flop chain, optional stability filter, output flop
// and rise/fall pulse flops. Next-state pulses are exported for the shared any_change flop.
module sync_chan
  import sync_pkg::*;
#(
  parameter int   NUM_STAGES = 2,
  parameter int   FILTER_LEN = 0,
  parameter logic RST_BIT    = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic rise_nxt,
  output logic fall_nxt
);
  localparam int CW = (FILTER_LEN > 0) ? clog2(FILTER_LEN + 1) : 1;

  logic [NUM_STAGES-1:0] stg;
  logic                  cand;
  logic                  q_nxt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) stg <= {NUM_STAGES{RST_BIT}};
    else      stg <= {stg[NUM_STAGES-2:0], d};
  end

  assign cand = stg[NUM_STAGES-1];

  generate
    if (FILTER_LEN == 0) begin : g_nofilt
      assign q_nxt = cand;
    end else begin : g_filt
      logic [CW-1:0] cnt;
      logic          done;

      // Count only while the candidate disagrees; any return to equality restarts it.
      assign done  = (cand != q) && (cnt == CW'(FILTER_LEN - 1));
      assign q_nxt = done ? cand : q;

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                   cnt <= '0;
        else if (cand == q || done) cnt <= '0;
        else                        cnt <= cnt + 1'b1;
      end
    end
  endgenerate

  assign rise_nxt = q_nxt & ~q;
  assign fall_nxt = ~q_nxt & q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q    <= RST_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      q    <= q_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end
endmodule

// File: rtl/multi_bit_sync.sv
// BUS_WIDTH independent quasi-static control bits brought into the CLK domain,
// with optional glitch filtering and per-channel edge pulses.
module multi_bit_sync
  import sync_pkg::*;
#(
  parameter int                   BUS_WIDTH  = 1,
  parameter int                   NUM_STAGES = 2,
  parameter int                   FILTER_LEN = 0,
  parameter logic [BUS_WIDTH-1:0] RST_VAL    = {BUS_WIDTH{1'b0}}
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic [BUS_WIDTH-1:0] rise_pulse,
  output logic [BUS_WIDTH-1:0] fall_pulse,
  output logic                 any_change
);
  `SYNC_CHECK_STAGES(NUM_STAGES)

  logic [BUS_WIDTH-1:0] rise_nxt;
  logic [BUS_WIDTH-1:0] fall_nxt;

  generate
    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_chan
      sync_chan #(
        .NUM_STAGES (NUM_STAGES),
        .FILTER_LEN (FILTER_LEN),
        .RST_BIT    (RST_VAL[i])
      ) u_chan (
        .CLK      (CLK),
        .RST      (RST),
        .d        (unsync_bus[i]),
        .q        (sync_bus[i]),
        .rise     (rise_pulse[i]),
        .fall     (fall_pulse[i]),
        .rise_nxt (rise_nxt[i]),
        .fall_nxt (fall_nxt[i])
      );
    end
  endgenerate

  // Fed from next-state pulses so it lands in the same cycle as the pulse flops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) any_change <= 1'b0;
    else      any_change <= |(rise_nxt | fall_nxt);
  end
endmodule

// File: tb/tb_multi_bit_sync.sv
// Directed bench for multi_bit_sync across four configurations sharing one clock and reset.
module tb_multi_bit_sync;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // A: NS=2 F=0   B: NS=3 F=0   C: NS=2 F=4   D: NS=2 F=2 RST_VAL=F
  logic [3:0] ua, ub, uc, ud;
  logic [3:0] sa, ra, fa, sb, rb, fb, sc, rc, fc, sd, rd, fd;
  logic       aa, ab, ac, ad;

  multi_bit_sync #(.BUS_WIDTH(4), .NUM_STAGES(2), .FILTER_LEN(0), .RST_VAL(4'h0)) dut_a (
    .CLK(CLK), .RST(RST), .unsync_bus(ua), .sync_bus(sa), .rise_pulse(ra), .fall_pulse(fa), .any_change(aa));
  multi_bit_sync #(.BUS_WIDTH(4), .NUM_STAGES(3), .FILTER_LEN(0), .RST_VAL(4'h0)) dut_b (
    .CLK(CLK), .RST(RST), .unsync_bus(ub), .sync_bus(sb), .rise_pulse(rb), .fall_pulse(fb), .any_change(ab));
  multi_bit_sync #(.BUS_WIDTH(4), .NUM_STAGES(2), .FILTER_LEN(4), .RST_VAL(4'h0)) dut_c (
    .CLK(CLK), .RST(RST), .unsync_bus(uc), .sync_bus(sc), .rise_pulse(rc), .fall_pulse(fc), .any_change(ac));
  multi_bit_sync #(.BUS_WIDTH(4), .NUM_STAGES(2), .FILTER_LEN(2), .RST_VAL(4'hF)) dut_d (
    .CLK(CLK), .RST(RST), .unsync_bus(ud), .sync_bus(sd), .rise_pulse(rd), .fall_pulse(fd), .any_change(ad));

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset;
    RST = 1'b0;
    ua = 4'h0; ub = 4'h0; uc = 4'h0; ud = 4'hF;
    tick(); tick();
    RST = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset();
    RST = 1'b0;
    #1;
    n_checks++;
    if (sa !== 4'h0 || ra !== 4'h0 || fa !== 4'h0 || aa !== 1'b0) begin
      n_fail++; $display("FAIL reset_a: got sync=%h rise=%h fall=%h any=%b, want 0/0/0/0", sa, ra, fa, aa);
    end
    n_checks++;
    if (sd !== 4'hF || rd !== 4'h0 || fd !== 4'h0 || ad !== 1'b0) begin
      n_fail++; $display("FAIL reset_d: got sync=%h rise=%h fall=%h any=%b, want F/0/0/0", sd, rd, fd, ad);
    end
    tick();
    RST = 1'b1;
  endtask

  task automatic test_basic;
    apply_reset();
    tick();
    ua = 4'b0101;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_checks++;
      case (e)
        1, 2: if (sa !== 4'h0 || ra !== 4'h0 || aa !== 1'b0) begin
          n_fail++; $display("FAIL basic_early e%0d: got sync=%b rise=%b any=%b, want 0000/0000/0", e, sa, ra, aa);
        end
        3: if (sa !== 4'b0101 || ra !== 4'b0101 || fa !== 4'h0 || aa !== 1'b1) begin
          n_fail++; $display("FAIL basic_edge3: got sync=%b rise=%b fall=%b any=%b, want 0101/0101/0000/1", sa, ra, fa, aa);
        end
        default: if (sa !== 4'b0101 || ra !== 4'h0 || fa !== 4'h0 || aa !== 1'b0) begin
          n_fail++; $display("FAIL basic_after: got sync=%b rise=%b fall=%b any=%b, want 0101/0000/0000/0", sa, ra, fa, aa);
        end
      endcase
    end
  endtask

  task automatic test_three_stage_fall;
    ub = 4'b0001;
    repeat (6) tick();
    n_checks++;
    if (sb !== 4'b0001) begin
      n_fail++; $display("FAIL ns3_setup: got sync=%b, want 0001", sb);
    end
    ub = 4'b0000;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if (e < 4) begin
        if (sb !== 4'b0001 || fb !== 4'h0) begin
          n_fail++; $display("FAIL ns3_early e%0d: got sync=%b fall=%b, want 0001/0000", e, sb, fb);
        end
      end else if (e == 4) begin
        if (sb !== 4'b0000 || fb !== 4'b0001 || rb !== 4'h0 || ab !== 1'b1) begin
          n_fail++; $display("FAIL ns3_edge4: got sync=%b fall=%b rise=%b any=%b, want 0000/0001/0000/1", sb, fb, rb, ab);
        end
      end else if (fb !== 4'h0 || ab !== 1'b0) begin
        n_fail++; $display("FAIL ns3_after: got fall=%b any=%b, want 0000/0", fb, ab);
      end
    end
  endtask

  task automatic test_filter;
    logic seen;
    apply_reset();
    tick();
    uc = 4'b0010;
    repeat (3) tick();
    uc = 4'b0000;
    seen = 1'b0;
    for (int e = 0; e < 10; e++) begin
      if (sc !== 4'h0 || rc !== 4'h0 || fc !== 4'h0 || ac !== 1'b0) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL filter_short: short glitch reached outputs, got %b want 0", seen);
    end
    uc = 4'b0010;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) begin
        uc = 4'b0000;
        n_checks++;
        if (sc !== 4'h0 || rc !== 4'h0) begin
          n_fail++; $display("FAIL filter_e5: got sync=%b rise=%b, want 0000/0000", sc, rc);
        end
      end
      if (e == 6) begin
        n_checks++;
        if (sc !== 4'b0010 || rc !== 4'b0010 || ac !== 1'b1) begin
          n_fail++; $display("FAIL filter_e6: got sync=%b rise=%b any=%b, want 0010/0010/1", sc, rc, ac);
        end
      end
      if (e == 7) begin
        n_checks++;
        if (sc !== 4'b0010 || rc !== 4'h0 || ac !== 1'b0) begin
          n_fail++; $display("FAIL filter_e7: got sync=%b rise=%b any=%b, want 0010/0000/0", sc, rc, ac);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    ud = 4'hF;
    tick();
    ud = 4'h0;
    repeat (3) tick();   // counter now at 1, one edge from committing
    RST = 1'b0;
    #1;
    n_checks++;
    if (sd !== 4'hF || rd !== 4'h0 || fd !== 4'h0 || ad !== 1'b0) begin
      n_fail++; $display("FAIL midrst_assert: got sync=%h rise=%h fall=%h any=%b, want F/0/0/0", sd, rd, fd, ad);
    end
    tick();
    RST = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if (e <= 3) begin
        if (sd !== 4'hF || fd !== 4'h0) begin
          n_fail++; $display("FAIL midrst_early e%0d: got sync=%h fall=%h, want F/0", e, sd, fd);
        end
      end else if (e == 4) begin
        if (sd !== 4'h0 || fd !== 4'hF || rd !== 4'h0 || ad !== 1'b1) begin
          n_fail++; $display("FAIL midrst_e4: got sync=%h fall=%h rise=%h any=%b, want 0/F/0/1", sd, fd, rd, ad);
        end
      end else if (fd !== 4'h0 || ad !== 1'b0) begin
        n_fail++; $display("FAIL midrst_after: got fall=%h any=%b, want 0/0", fd, ad);
      end
    end
  endtask

  task automatic test_back_to_back;
    int any_cnt;
    ua = 4'b1000;
    repeat (5) tick();
    n_checks++;
    if (sa !== 4'b1000) begin
      n_fail++; $display("FAIL opp_setup: got sync=%b, want 1000", sa);
    end
    ua = 4'b0100;
    any_cnt = 0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (aa === 1'b1) any_cnt++;
      if (e == 3) begin
        n_checks++;
        if (ra !== 4'b0100 || fa !== 4'b1000 || aa !== 1'b1 || sa !== 4'b0100) begin
          n_fail++; $display("FAIL opp_e3: got rise=%b fall=%b any=%b sync=%b, want 0100/1000/1/0100", ra, fa, aa, sa);
        end
      end
    end
    n_checks++;
    if (any_cnt !== 1) begin
      n_fail++; $display("FAIL opp_any_width: got %0d cycles of any_change, want 1", any_cnt);
    end
  endtask

  int         in_edges [4];
  int         pulses   [4];
  logic [3:0] prev_sync;

  task automatic observe_c;
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (rc[b] !== (sc[b] & ~prev_sync[b]) || fc[b] !== (~sc[b] & prev_sync[b])) begin
        n_fail++; $display("FAIL rand_pulse b%0d: got rise=%b fall=%b sync %b->%b", b, rc[b], fc[b], prev_sync[b], sc[b]);
      end
      if (rc[b] === 1'b1 || fc[b] === 1'b1) pulses[b]++;
    end
    n_checks++;
    if (ac !== |(rc | fc)) begin
      n_fail++; $display("FAIL rand_any: got %b, want %b", ac, |(rc | fc));
    end
    prev_sync = sc;
  endtask

  task automatic test_random;
    logic [3:0] nv;
    apply_reset();
    prev_sync = 4'h0;
    for (int b = 0; b < 4; b++) begin in_edges[b] = 0; pulses[b] = 0; end
    for (int s = 0; s < 20; s++) begin
      nv = 4'($urandom);
      for (int b = 0; b < 4; b++) if (nv[b] != uc[b]) in_edges[b]++;
      uc = nv;
      repeat ($urandom_range(8, 12)) begin tick(); observe_c(); end
    end
    repeat (10) begin tick(); observe_c(); end
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (pulses[b] !== in_edges[b]) begin
        n_fail++; $display("FAIL rand_count b%0d: got %0d pulses, want %0d", b, pulses[b], in_edges[b]);
      end
    end
    n_checks++;
    if (sc !== uc) begin
      n_fail++; $display("FAIL rand_final: got sync=%b, want %b", sc, uc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_three_stage_fall();
    test_back_to_back();
    test_filter();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_bit_sync.md
Name: multi_bit_sync

Overview:
- Parametrised multi-channel successor to the single-bit two-flop synchroniser.
- Brings BUS_WIDTH independent quasi-static control bits from a foreign clock domain into the CLK domain through a configurable flop chain.
- Adds an optional per-channel stability (glitch) filter, plus per-channel rise/fall pulse outputs.
- Used on config/enable/status lines crossing into the SYS/REF/UART clock domains. Not intended for multi-bit coherent data; use the data synchroniser for that.

Parameters:
- BUS_WIDTH, 1: number of independent channels.
- NUM_STAGES, 2: synchroniser flops per channel; legal range 2..4, elaboration error otherwise.
- FILTER_LEN, 0: 0 = filter bypassed; N>0 = the synchronised value must be stable for N consecutive CLK cycles before sync_bus follows it.
- RST_VAL, {BUS_WIDTH{1'b0}}: reset value of all chain flops and of sync_bus.

Ports:
- CLK  input  1  destination-domain clock.
- RST  input  1  asynchronous, active-low reset.
- unsync_bus  input  BUS_WIDTH  asynchronous inputs; each bit treated independently.
- sync_bus  output  BUS_WIDTH  synchronised (and filtered) value, registered.
- rise_pulse  output  BUS_WIDTH  one-cycle pulse when sync_bus[i] goes 0->1.
- fall_pulse  output  BUS_WIDTH  one-cycle pulse when sync_bus[i] goes 1->0.
- any_change  output  1  OR-reduction of (rise_pulse | fall_pulse), registered-aligned with the pulses.

Behaviour:
- Reset (RST low, async): all chain stages = RST_VAL; sync_bus = RST_VAL; filter counters = 0; rise_pulse, fall_pulse, any_change = 0.
- Reset release: no pulse is generated by the release itself.
- Chain: stage[0] <= unsync_bus; stage[k] <= stage[k-1]; cand = stage[NUM_STAGES-1].
- FILTER_LEN=0:
  - sync_bus <= cand.
  - Latency from a stable input change to sync_bus = NUM_STAGES+1 edges.
  - A single-cycle sampled glitch propagates unchanged.
- FILTER_LEN=N>0, per channel:
  - cnt is ceil(log2(N+1)) bits.
  - If cand[i]==sync_bus[i]: cnt <= 0.
  - Else if cnt==N-1: sync_bus[i] <= cand[i], cnt <= 0.
  - Else: cnt <= cnt+1.
  - Latency = NUM_STAGES+N edges.
  - A cand pulse shorter than N cycles never reaches sync_bus; the counter restarts from 0 after any return to equality.
- Pulses:
  - rise_pulse[i]/fall_pulse[i] are registered in the same edge that updates sync_bus[i].
  - They are high exactly for the first cycle sync_bus[i] shows its new value.
  - Never both high on one channel; independent channels may pulse simultaneously.
  - any_change is high in the same cycle as any pulse.
- Counter wrap: impossible; cnt saturates by construction at N-1 before clearing.
- Reset mid-operation: all state cleared immediately, including any in-flight pulse and partial counts. The pending change is re-evaluated from scratch after release.
- No combinational path from unsync_bus to any output. All outputs are flop outputs, except any_change, which is a flop fed by the OR of the next-state pulses.

Decomposition:
- sync_pkg holds:
  - constants MIN_SYNC_STAGES=2 and MAX_SYNC_STAGES=4;
  - a clog2 helper function for counter sizing;
  - a parameter-legality check macro.
- Sub-module sync_chan: one channel containing the chain, filter counter, sync flop and rise/fall flops. multi_bit_sync instantiates BUS_WIDTH copies in a generate loop and ORs the pulses into any_change.

Test Plan:
- BUS_WIDTH=4, NUM_STAGES=2, FILTER_LEN=0, RST_VAL=0: drive unsync_bus 0000->0101 one cycle after reset release -> sync_bus=0101 three edges later; rise_pulse=0101 for exactly that cycle; any_change=1 for that cycle; fall_pulse=0000 throughout.
- NUM_STAGES=3: toggle bit0 1->0 -> sync_bus[0] falls on the 4th edge; fall_pulse[0] high for one cycle, aligned with it.
- FILTER_LEN=4: a 3-cycle-wide high on bit1 -> sync_bus, pulses and any_change remain 0. Then a 5-cycle-wide high -> sync_bus[1]=1 at edge NUM_STAGES+4 after the change; single rise_pulse[1].
- RST_VAL=1111, FILTER_LEN=2: assert RST with the filter counter at 1 and the input at 0 -> outputs immediately 1111, pulses 0. Release with the input still 0 -> sync_bus=0000 after NUM_STAGES+2 edges, with fall_pulse=1111 once.
- Simultaneous opposite edges on bits 2 and 3 -> rise_pulse[2] and fall_pulse[3] in the same cycle; any_change a single one-cycle pulse.
- Randomised asynchronous toggling held at least NUM_STAGES+FILTER_LEN+1 cycles per level -> scoreboard: every sync_bus transition matches exactly one pulse, and input edges map one-to-one onto pulses.
